// File: rtl/line_xfer_arb.sv
// line_xfer_arb: arbitrates the dcache and icache onto a single nibble-wide
// memory port. A dcache grant may write back its dirty victim line before
// filling; an icache grant only fills. Two requesters share the port
// round-robin, and every transfer ends with a one-cycle done pulse.
module line_xfer_arb #(
  parameter int LINE_LENGTH = 4,
  parameter int PA          = 22,
  localparam int OFF        = $clog2(LINE_LENGTH)
) (
  input  logic                clk,
  input  logic                reset,
  // dcache side
  input  logic                d_push,
  input  logic                d_pull,
  input  logic [PA-OFF-1:0]   d_wb_tag,
  input  logic [PA-OFF-1:0]   d_fill_tag,
  input  logic [3:0]          d_wnib,
  output logic                d_rstrobe,
  output logic                d_wstrobe,
  output logic [3:0]          d_dread,
  // icache side
  input  logic                i_pull,
  input  logic [PA-OFF-1:0]   i_fill_tag,
  output logic                i_wstrobe,
  output logic [3:0]          i_dread,
  // completion pulses
  output logic                d_done,
  output logic                i_done,
  // memory side
  output logic                mem_req,
  output logic                mem_write,
  output logic [PA-1:0]       mem_addr,
  input  logic                mem_ack,
  output logic [3:0]          mem_wdata,
  input  logic                mem_wready,
  input  logic [3:0]          mem_rdata,
  input  logic                mem_rvalid
);

  localparam int NIB = 2 * LINE_LENGTH;
  localparam int CW  = $clog2(NIB);
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_DATA,
    FILL_REQ,
    FILL_DATA,
    DONE
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                last_d;
  logic                owner_d;
  logic                pull_lat;
  logic [PA-OFF-1:0]   fill_tag_lat;
  logic                last_fill;   // final fill nibble captured, strobe in flight

  logic                d_req;
  logic                grant_d;
  logic [PA-OFF-1:0]   grant_fill_tag;

  // Round-robin choice: dcache wins a tie only when the icache went last.
  always_comb begin
    d_req          = d_push | d_pull;
    grant_d        = d_req & (~i_pull | ~last_d);
    grant_fill_tag = grant_d ? d_fill_tag : i_fill_tag;
  end

  // Writeback data flows straight from the dcache; each accepted nibble
  // advances the victim pointer in the same cycle.
  always_comb begin
    mem_wdata = d_wnib;
    d_rstrobe = (state == WB_DATA) & mem_wready;
  end

  // Transfer FSM with registered memory-side and cache-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_d       <= 1'b0;
      owner_d      <= 1'b0;
      pull_lat     <= 1'b0;
      fill_tag_lat <= '0;
      last_fill    <= 1'b0;
      mem_req      <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      d_wstrobe    <= 1'b0;
      i_wstrobe    <= 1'b0;
      d_dread      <= '0;
      i_dread      <= '0;
      d_done       <= 1'b0;
      i_done       <= 1'b0;
    end else begin
      // Strobes and done are single-cycle pulses unless re-armed below.
      d_wstrobe <= 1'b0;
      i_wstrobe <= 1'b0;
      d_done    <= 1'b0;
      i_done    <= 1'b0;

      case (state)
        IDLE: begin
          if (d_req | i_pull) begin
            owner_d      <= grant_d;
            pull_lat     <= grant_d & d_pull;
            fill_tag_lat <= grant_fill_tag;
            mem_req      <= 1'b1;
            if (grant_d & d_push) begin
              state     <= WB_REQ;
              mem_write <= 1'b1;
              mem_addr  <= {d_wb_tag, {OFF{1'b0}}};
            end else begin
              state     <= FILL_REQ;
              mem_write <= 1'b0;
              mem_addr  <= {grant_fill_tag, {OFF{1'b0}}};
            end
          end
        end

        WB_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            state   <= WB_DATA;
          end
        end

        WB_DATA: begin
          if (mem_wready) begin
            if (cnt == LAST_NIB) begin
              cnt <= '0;
              if (pull_lat) begin
                state     <= FILL_REQ;
                mem_req   <= 1'b1;
                mem_write <= 1'b0;
                mem_addr  <= {fill_tag_lat, {OFF{1'b0}}};
              end else begin
                // Writeback-only transfers always belong to the dcache.
                state  <= DONE;
                d_done <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        FILL_REQ: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            cnt       <= '0;
            last_fill <= 1'b0;
            state     <= FILL_DATA;
          end
        end

        FILL_DATA: begin
          if (last_fill) begin
            // Final wstrobe is on the wire this cycle; finish up.
            last_fill <= 1'b0;
            state     <= DONE;
            d_done    <= owner_d;
            i_done    <= ~owner_d;
          end else if (mem_rvalid) begin
            if (owner_d) begin
              d_dread   <= mem_rdata;
              d_wstrobe <= 1'b1;
            end else begin
              i_dread   <= mem_rdata;
              i_wstrobe <= 1'b1;
            end
            if (cnt == LAST_NIB) begin
              last_fill <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        DONE: begin
          last_d <= owner_d;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/line_xfer_arb.md
LINE_XFER_ARB -- requirements
Module: line_xfer_arb

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 4, cache line length in bytes; NIB = 2*LINE_LENGTH nibbles per line.
REQ-002 SHALL have parameter PA, default 22, physical address width; OFF = log2(LINE_LENGTH).
REQ-003 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- d_push  in  1  dcache needs its dirty victim written back.
- d_pull  in  1  dcache needs a line filled.
- d_wb_tag  in  PA-OFF  victim line address.
- d_fill_tag  in  PA-OFF  fill line address.
- d_wnib  in  4  current victim nibble from the dcache.
- d_rstrobe  out  1  dcache advances its victim nibble.
- d_wstrobe  out  1  dcache writes d_dread into its line.
- d_dread  out  4  fill nibble to the dcache.
- i_pull  in  1  icache needs a line filled.
- i_fill_tag  in  PA-OFF  icache fill line address.
- i_wstrobe  out  1  icache writes i_dread into its line.
- i_dread  out  4  fill nibble to the icache.
- d_done, i_done  out  1  one-cycle completion pulses.
- mem_req  out  1  memory transaction request.
- mem_write  out  1  1 = writeback, 0 = fill.
- mem_addr  out  PA  line-aligned address, low OFF bits zero.
- mem_ack  in  1  memory accepted the request.
- mem_wdata  out  4  writeback nibble.
- mem_wready  in  1  memory consumed mem_wdata this cycle.
- mem_rdata  in  4  fill nibble.
- mem_rvalid  in  1  mem_rdata valid this cycle.

Function
REQ-004 SHALL implement the states IDLE, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA and DONE.
REQ-005 IDLE SHALL sample requests only in IDLE; requester changes at any other time are ignored until the next IDLE.
REQ-006 Arbitration SHALL be two-way round-robin.
- last_d flag records which requester was served last; it is 0 at reset.
- On d_push|d_pull together with i_pull, the dcache wins if last_d=0, otherwise the icache wins.
- A lone request wins outright.
REQ-007 Granting the dcache with d_push=1 SHALL go to WB_REQ; d_pull alone or an icache grant SHALL go to FILL_REQ. The owner and the tags SHALL be latched at grant.
REQ-008 WB_REQ SHALL drive mem_req=1, mem_write=1 and mem_addr={d_wb_tag,OFF zeros}, holding them until mem_ack, then go to WB_DATA with cnt=0.
REQ-009 In WB_DATA, mem_wdata SHALL equal d_wnib combinationally, and each mem_wready cycle SHALL:
- pulse d_rstrobe the same cycle;
- increment cnt.
On mem_wready with cnt=NIB-1, the block SHALL go to FILL_REQ if the latched d_pull=1, otherwise to DONE.
REQ-010 FILL_REQ SHALL drive mem_req=1, mem_write=0 and mem_addr={owner fill tag,OFF zeros} until mem_ack, then go to FILL_DATA with cnt=0.
REQ-011 In FILL_DATA, each mem_rvalid SHALL:
- register mem_rdata into the owner's d_dread or i_dread;
- pulse the owner's wstrobe exactly one cycle later;
- increment cnt.
The non-owner's wstrobe SHALL stay 0.
REQ-012 After the wstrobe for nibble NIB-1 has been issued, the block SHALL go to DONE; at most one wstrobe pulse SHALL be issued per mem_rvalid.
REQ-013 DONE SHALL pulse the owner's done for one cycle, update last_d to 1 if the dcache was the owner and 0 otherwise, and return to IDLE.
REQ-014 mem_req SHALL be 0 outside WB_REQ and FILL_REQ, and mem_req SHALL be 0 in the cycle after mem_ack.
REQ-015 mem_wready outside WB_DATA and mem_rvalid outside FILL_DATA SHALL be ignored.
REQ-016 cnt SHALL be log2(NIB) bits wide and SHALL never wrap inside a transaction.
REQ-017 Back-to-back transactions SHALL take at least one IDLE cycle between DONE and the next grant.

Reset
REQ-018 Reset SHALL, at any state including mid-transfer:
- force IDLE, cnt=0 and last_d=0;
- drive mem_req, mem_write, d_rstrobe, d_wstrobe, i_wstrobe, d_done and i_done to 0;
- drive d_dread, i_dread and mem_addr to 0.
REQ-019 The first grant after reset SHALL be evaluated no earlier than the first cycle with reset=0.

Verification
REQ-020 LINE_LENGTH=4, d_pull only, d_fill_tag=0x1234, mem_ack after 2 cycles, 8 rvalid nibbles 1..8 -> mem_addr=0x048D0, mem_write=0, then 8 d_wstrobe pulses each 1 cycle after its rvalid with d_dread=1..8, then d_done, and i_wstrobe never asserted.
REQ-021 d_push+d_pull, d_wb_tag=0x0010, mem_wready every cycle -> 8 d_rstrobe pulses with mem_wdata tracking d_wnib, then a second mem_req with mem_write=0 at the fill address, then the fill proceeds as in REQ-020.
REQ-022 d_pull and i_pull held continuously from reset -> grant order dcache, icache, dcache, ..., with exactly one done per transaction.
REQ-023 Reset asserted after the 3rd fill nibble -> next cycle is IDLE with all strobes 0 and mem_req=0; after reset the request is re-served from cnt=0.
REQ-024 Spurious mem_rvalid while in WB_DATA and spurious mem_wready while in FILL_DATA -> no strobe and no change to cnt.
